// File: rtl/reaction_timer_multi_pkg.sv
// Shared types and helpers for the multi-digit reaction timer.
package reaction_timer_multi_pkg;

    // Top-level controller states; encoding is fixed so debug probes stay meaningful.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_REACT = 3'd2,
        ST_SHOW  = 3'd3,
        ST_FOUL  = 3'd4
    } state_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One LFSR step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // BCD value with the lowest `digits` nibbles set to 9 (at most 8 digits).
    function automatic logic [31:0] bcd_all_nines(input int unsigned digits);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < digits) begin
                v[i*4 +: 4] = 4'd9;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/reaction_timer_multi_if.sv
// Control/status bundle between the reaction timer and its user side
// (buttons, selector switch, LEDs and the seven-segment scanner).
interface reaction_timer_multi_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned SELW = $clog2(DIGITS);

    logic            start_trigger;
    logic            user_trigger;
    logic            show_best;
    logic            go_led;
    logic            false_start;
    logic            result_valid;
    logic            overflow;
    logic            new_best;
    logic [3:0]      digit;
    logic [SELW-1:0] digit_sel;

    // User side: drives the buttons and selector, observes lamps and display.
    modport master (
        output start_trigger, user_trigger, show_best,
        input  go_led, false_start, result_valid, overflow, new_best,
               digit, digit_sel
    );

    // Timer side.
    modport slave (
        input  start_trigger, user_trigger, show_best,
        output go_led, false_start, result_valid, overflow, new_best,
               digit, digit_sel
    );

endinterface

// File: rtl/reaction_timer_multi_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear that holds at all 9s.
module bcd_counter
    import reaction_timer_multi_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] value,
    output logic                full
);

    localparam int unsigned    W     = 4 * DIGITS;
    localparam logic [W-1:0]   NINES = W'(bcd_all_nines(DIGITS));

    logic [W-1:0] incremented;

    assign full = (value == NINES);

    // Ripple the +1 through the digits: a 9 rolls to 0 and passes the carry on.
    always_comb begin : ripple
        logic carry;
        incremented = value;
        carry       = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    incremented[i*4 +: 4] = 4'd0;
                end else begin
                    incremented[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
    end

    // Count register; increments requested at all 9s are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !full) begin
            value <= incremented;
        end
    end

endmodule

// File: rtl/reaction_timer_multi.sv
// Reaction-time benchmark: random go delay, false-start detection,
// saturating BCD millisecond result, best-time memory and a scanned
// digit output for the seven-segment display driver.
module reaction_timer_multi
    import reaction_timer_multi_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000,
    parameter int unsigned TICKS_PER_MS = CLK_HZ / 1000,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned SCAN_DIV     = 1
) (
    input logic                  clk,
    input logic                  rst,
    reaction_timer_multi_if.slave bus
);

    localparam int unsigned       W         = 4 * DIGITS;
    localparam int unsigned       PW        = $clog2(TICKS_PER_MS);
    localparam int unsigned       SELW      = $clog2(DIGITS);
    localparam int unsigned       SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]     PRE_LAST  = PW'(TICKS_PER_MS - 1);
    localparam logic [SELW-1:0]   SEL_LAST  = SELW'(DIGITS - 1);
    localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [15:0]       RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);
    localparam logic [W-1:0]      NINES     = W'(bcd_all_nines(DIGITS));

    state_t          state;
    logic [15:0]     lfsr;
    logic            armed;
    logic            start_q;
    logic            user_q;
    logic            start_rise;
    logic            user_rise;
    logic [PW-1:0]   pre;
    logic            pre_wrap;
    logic [31:0]     delay_ms;
    logic [31:0]     ms_cnt;
    logic            go_led;
    logic            false_start;
    logic            result_valid;
    logic            overflow;
    logic            new_best;
    logic [W-1:0]    result;
    logic [W-1:0]    best;
    logic            res_full;
    logic            enter_wait;
    logic            res_inc;
    logic [SW-1:0]   scan_cnt;
    logic            scan_adv;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] sel_nxt;
    logic [W-1:0]    src;
    logic [3:0]      digit;

    // `armed` masks the first cycle after reset so a button already held
    // at reset release is captured as the old level rather than seen as a rise.
    assign start_rise = armed & bus.start_trigger & ~start_q;
    assign user_rise  = armed & bus.user_trigger  & ~user_q;
    assign pre_wrap   = (pre == PRE_LAST);

    assign enter_wait = start_rise &&
                        ((state == ST_IDLE) || (state == ST_SHOW) || (state == ST_FOUL));
    // The tick coinciding with the user press is dropped so the shown count
    // equals the value present when the press was detected.
    assign res_inc    = (state == ST_REACT) && pre_wrap && !user_rise;

    // Trigger history for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed   <= 1'b0;
            start_q <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            armed   <= 1'b1;
            start_q <= bus.start_trigger;
            user_q  <= bus.user_trigger;
        end
    end

    // Free-running random source, stepped every clock in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_result (
        .clk   (clk),
        .rst   (rst),
        .clr   (enter_wait),
        .inc   (res_inc),
        .value (result),
        .full  (res_full)
    );

    // Controller: state, delay timing, ms prescaler, best time and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            pre          <= '0;
            delay_ms     <= '0;
            ms_cnt       <= '0;
            go_led       <= 1'b0;
            false_start  <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            new_best     <= 1'b0;
            best         <= NINES;
        end else begin
            new_best <= 1'b0;
            unique case (state)
                ST_IDLE, ST_SHOW, ST_FOUL: begin
                    if (start_rise) begin
                        state        <= ST_WAIT;
                        delay_ms     <= MIN_DELAY_MS + 32'(lfsr & RAND_MASK);
                        ms_cnt       <= '0;
                        pre          <= '0;
                        overflow     <= 1'b0;
                        go_led       <= 1'b0;
                        false_start  <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (user_rise) begin
                        state       <= ST_FOUL;
                        false_start <= 1'b1;
                    end else begin
                        pre <= pre_wrap ? '0 : pre + 1'b1;
                        if (pre_wrap) begin
                            ms_cnt <= ms_cnt + 32'd1;
                            if (ms_cnt == delay_ms - 32'd1) begin
                                state  <= ST_REACT;
                                go_led <= 1'b1;
                            end
                        end
                    end
                end
                ST_REACT: begin
                    if (user_rise) begin
                        state        <= ST_SHOW;
                        go_led       <= 1'b0;
                        result_valid <= 1'b1;
                        if (!overflow && (result < best)) begin
                            best     <= result;
                            new_best <= 1'b1;
                        end
                    end else begin
                        pre <= pre_wrap ? '0 : pre + 1'b1;
                        if (pre_wrap && res_full) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan_adv = (scan_cnt == SCAN_LAST);
    assign src      = bus.show_best ? best : result;

    // Next display index, wrapping at DIGITS-1 even when DIGITS is not a power of two.
    always_comb begin
        sel_nxt = sel;
        if (scan_adv) begin
            sel_nxt = (sel == SEL_LAST) ? '0 : sel + 1'b1;
        end
    end

    // Display scan: the nibble is fetched with the index it is presented with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            sel      <= '0;
            digit    <= '0;
        end else begin
            scan_cnt <= scan_adv ? '0 : scan_cnt + 1'b1;
            sel      <= sel_nxt;
            digit    <= 4'(src >> {sel_nxt, 2'b00});
        end
    end

    assign bus.go_led       = go_led;
    assign bus.false_start  = false_start;
    assign bus.result_valid = result_valid;
    assign bus.overflow     = overflow;
    assign bus.new_best     = new_best;
    assign bus.digit        = digit;
    assign bus.digit_sel    = sel;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi: a 4-digit and a 3-digit instance share
// stimulus; a decimal reference model predicts result, best and flags.
module tb_reaction_timer_multi;

    // 2 clocks per ms keeps a >9999 ms saturation run short.
    localparam int unsigned T      = 2;
    localparam int unsigned MIN_MS = 2;
    localparam int unsigned N      = T * MIN_MS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reaction_timer_multi_if #(.DIGITS(4)) bus4 ();
    reaction_timer_multi_if #(.DIGITS(3)) bus3 ();

    reaction_timer_multi #(
        .CLK_HZ(2000), .TICKS_PER_MS(T), .DIGITS(4), .MIN_DELAY_MS(MIN_MS),
        .RAND_BITS(0), .LFSR_SEED(16'hACE1), .SCAN_DIV(1)
    ) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    reaction_timer_multi #(
        .CLK_HZ(2000), .TICKS_PER_MS(T), .DIGITS(3), .MIN_DELAY_MS(MIN_MS),
        .RAND_BITS(0), .LFSR_SEED(16'hACE1), .SCAN_DIV(1)
    ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: index 0 = 4-digit instance, 1 = 3-digit instance.
    int unsigned digs[2] = '{4, 3};
    int unsigned maxv[2] = '{9999, 999};
    int unsigned best_m[2];
    int unsigned res_m[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned pow10(input int unsigned e);
        int unsigned r = 1;
        for (int unsigned i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic string pfx(input int k);
        return (k == 0) ? "d4." : "d3.";
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input bit s, input bit u);
        bus4.start_trigger = s; bus3.start_trigger = s;
        bus4.user_trigger  = u; bus3.user_trigger  = u;
    endtask

    task automatic set_sb(input bit b);
        bus4.show_best = b; bus3.show_best = b;
    endtask

    task automatic get_out(input int k, output logic [31:0] go, output logic [31:0] fs,
                           output logic [31:0] rv, output logic [31:0] ov,
                           output logic [31:0] nb, output logic [31:0] dg,
                           output logic [31:0] sl);
        if (k == 0) begin
            go = 32'(bus4.go_led); fs = 32'(bus4.false_start); rv = 32'(bus4.result_valid);
            ov = 32'(bus4.overflow); nb = 32'(bus4.new_best); dg = 32'(bus4.digit);
            sl = 32'(bus4.digit_sel);
        end else begin
            go = 32'(bus3.go_led); fs = 32'(bus3.false_start); rv = 32'(bus3.result_valid);
            ov = 32'(bus3.overflow); nb = 32'(bus3.new_best); dg = 32'(bus3.digit);
            sl = 32'(bus3.digit_sel);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] go, fs, rv, ov, nb, dg, sl;
        for (int k = 0; k < 2; k++) begin
            get_out(k, go, fs, rv, ov, nb, dg, sl);
            chk({pfx(k), tag, ".go_led"}, go, 0);
            chk({pfx(k), tag, ".false_start"}, fs, 0);
            chk({pfx(k), tag, ".result_valid"}, rv, 0);
            chk({pfx(k), tag, ".overflow"}, ov, 0);
            chk({pfx(k), tag, ".new_best"}, nb, 0);
            chk({pfx(k), tag, ".digit"}, dg, 0);
            chk({pfx(k), tag, ".digit_sel"}, sl, 0);
        end
    endtask

    // Walk the display for a few wraps and compare each (index, digit) pair
    // with the decimal digit of the model value at that index.
    task automatic scan_check(input bit sb);
        logic [31:0] go, fs, rv, ov, nb, dg, sl;
        logic [31:0] prev[2];
        int unsigned v;
        set_sb(sb);
        step();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                get_out(k, go, fs, rv, ov, nb, dg, sl);
                if (i > 0) chk({pfx(k), "scan_sel"}, sl, (prev[k] + 1) % digs[k]);
                v = sb ? best_m[k] : res_m[k];
                chk({pfx(k), sb ? "scan_best" : "scan_result"}, dg, (v / pow10(sl)) % 10);
                prev[k] = sl;
            end
            step();
        end
    endtask

    // One attempt: start rise, then the user rise is seen m+1 edges after WAIT entry.
    task automatic do_run(input int unsigned m_in, input bit both, input bit poke);
        logic [31:0] go, fs, rv, ov, nb, dg, sl;
        int unsigned m, u_rel, ticks;
        bit foul, ovf, nbe;
        m = m_in;
        if (both && m == 0) m = 1;
        set_in(1'b1, both);
        step();
        set_in(1'b0, 1'b0);
        for (int unsigned j = 0; j <= m; j++) begin
            if (j == N - 1 || j == N) begin
                for (int k = 0; k < 2; k++) begin
                    get_out(k, go, fs, rv, ov, nb, dg, sl);
                    chk({pfx(k), "go_latency"}, go, 32'(j >= N));
                end
            end
            if (j < m) begin
                set_in(poke && j == 1, 1'b0);
                step();
            end
        end
        set_in(1'b0, 1'b1);
        step();
        u_rel = m + 1;
        foul  = (u_rel <= N);
        for (int k = 0; k < 2; k++) begin
            if (foul) begin
                res_m[k] = 0; ovf = 0; nbe = 0;
            end else begin
                ticks    = (u_rel - N - 1) / T;
                ovf      = ticks > maxv[k];
                res_m[k] = ovf ? maxv[k] : ticks;
                nbe      = !ovf && (res_m[k] < best_m[k]);
                if (nbe) best_m[k] = res_m[k];
            end
            get_out(k, go, fs, rv, ov, nb, dg, sl);
            chk({pfx(k), "false_start"}, fs, 32'(foul));
            chk({pfx(k), "result_valid"}, rv, 32'(!foul));
            chk({pfx(k), "go_led_off"}, go, 0);
            chk({pfx(k), "overflow"}, ov, 32'(ovf));
            chk({pfx(k), "new_best"}, nb, 32'(nbe));
        end
        step();
        for (int k = 0; k < 2; k++) begin
            get_out(k, go, fs, rv, ov, nb, dg, sl);
            chk({pfx(k), "new_best_pulse_end"}, nb, 0);
        end
        set_in(1'b0, 1'b0);
        step();
    endtask

    function automatic int unsigned ms_press(input int unsigned ms);
        return N + ms * T + $urandom_range(0, T - 1);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] go, fs, rv, ov, nb, dg, sl;
        int unsigned m;
        for (int k = 0; k < 2; k++) begin
            best_m[k] = maxv[k];
            res_m[k]  = 0;
        end
        set_in(1'b0, 1'b0);
        set_sb(1'b0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        step();
        scan_check(1'b1);

        // Basic run, then false starts including the expiry-cycle collision.
        do_run(ms_press(1234), 1'b0, 1'b0);
        scan_check(1'b0);
        scan_check(1'b1);
        do_run($urandom_range(0, N - 2), 1'b0, 1'b0);
        scan_check(1'b0);
        do_run(N - 1, 1'b0, 1'b0);
        scan_check(1'b0);

        // Best tracking.
        do_run(ms_press(300), 1'b0, 1'b0);
        do_run(ms_press(450), 1'b1, 1'b1);
        scan_check(1'b1);
        do_run(ms_press(120), 1'b0, 1'b1);
        scan_check(1'b1);

        // Saturation of both widths.
        do_run(ms_press(10005), 1'b0, 1'b0);
        scan_check(1'b0);

        // Randomised attempts.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) m = $urandom_range(0, N - 1);
            else                           m = ms_press($urandom_range(0, 980));
            do_run(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            scan_check(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while in REACT, with start held through release.
        set_in(1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0);
        repeat (N + 20) step();
        for (int k = 0; k < 2; k++) begin
            get_out(k, go, fs, rv, ov, nb, dg, sl);
            chk({pfx(k), "pre_reset_go"}, go, 1);
        end
        #3;
        rst = 1'b0;
        set_in(1'b1, 1'b0);
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3 * N) step();
        for (int k = 0; k < 2; k++) begin
            best_m[k] = maxv[k];
            res_m[k]  = 0;
            get_out(k, go, fs, rv, ov, nb, dg, sl);
            chk({pfx(k), "held_start_go"}, go, 0);
            chk({pfx(k), "held_start_fs"}, fs, 0);
            chk({pfx(k), "held_start_rv"}, rv, 0);
        end
        scan_check(1'b1);
        scan_check(1'b0);
        set_in(1'b0, 1'b0);
        step();
        do_run(ms_press(7), 1'b0, 1'b0);
        scan_check(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer_multi.md
Name: reaction_timer_multi

Overview:
- Parametrised next-generation reaction-time benchmark: pseudo-random go delay, false-start detection, N-digit saturating BCD millisecond counter, best-time memory, scanned digit output.
- Drives the existing seven_segment_display through `digit`/`digit_sel`.
- Replaces the fixed-delay, fixed-4-digit benchmark.

Parameters:
- CLK_HZ, 50000: system clock frequency in Hz.
- TICKS_PER_MS, CLK_HZ/1000: clocks per millisecond tick; must be ≥ 2.
- DIGITS, 4: BCD digits of result; range 2..8.
- MIN_DELAY_MS, 1000: fixed part of go delay in ms; must be ≥ 1.
- RAND_BITS, 12: random extra delay of 0..2^RAND_BITS-1 ms; range 0..15, where 0 means no random part.
- LFSR_SEED, 16'hACE1: non-zero reset seed.
- SCAN_DIV, 1: clocks per display digit step; must be ≥ 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset; asynchronous, active-low (0 = reset).
- start_trigger, in, 1: start/restart request, active high, synchronous, rising-edge used.
- user_trigger, in, 1: user response, active high, synchronous, rising-edge used.
- show_best, in, 1: 1 = display best time, 0 = display last result.
- go_led, out, 1: high while in REACT.
- false_start, out, 1: high while in FOUL.
- result_valid, out, 1: high while in SHOW.
- overflow, out, 1: last result saturated at all-9s.
- new_best, out, 1: one-cycle pulse when best time is updated.
- digit, out, 4: BCD nibble currently scanned.
- digit_sel, out, $clog2(DIGITS): index of scanned digit; 0 = ones.

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0.
  - Result = 0; best = all 9s; lfsr = LFSR_SEED.
  - Prescaler, delay counter and edge registers = 0.
- Edge detect: registered copy of each trigger; rise = in & ~q. A trigger already high at reset release is not a rise.
- LFSR: 16-bit Galois, taps 16,14,13,11, steps every clock in every state.
- States and transitions:
  - IDLE: start rise → WAIT.
  - WAIT:
    - On entry, latch delay_ms = MIN_DELAY_MS + (lfsr & (2^RAND_BITS-1)); clear prescaler; clear result and overflow.
    - Stay exactly delay_ms*TICKS_PER_MS cycles, then → REACT.
    - User rise in WAIT → FOUL.
    - Start rise in WAIT is ignored.
  - REACT:
    - Prescaler counts 0..TICKS_PER_MS-1; each wrap increments result by 1 ms (BCD, ripple carry over DIGITS).
    - At all-9s, increments stop and overflow = 1.
    - User rise → SHOW; the count is frozen at the value present in that cycle (tick in the same cycle is dropped).
  - SHOW:
    - On the entry edge, if result < best (nibble-concatenated compare is valid for BCD) and overflow = 0, then best ← result and new_best pulses 1 cycle.
    - Start rise → WAIT.
  - FOUL: result unchanged (0); start rise → WAIT.
- Simultaneous rises:
  - IDLE/SHOW/FOUL: start wins.
  - WAIT: user wins (→ FOUL).
  - REACT: user wins, start ignored.
  - WAIT expiry in the same cycle as a user rise → FOUL.
- Display scan:
  - digit_sel advances every SCAN_DIV cycles, wrapping DIGITS-1 → 0 (non-power-of-two DIGITS handled).
  - digit is registered on the same edge as digit_sel, so the pair is always aligned.
  - Source = best if show_best, else result.
  - Scan runs in all states.
- Reset mid-operation: immediate return to reset values; best time is lost.

Decomposition:
- Shared package/header reaction_pkg:
  - State encoding: IDLE = 0, WAIT = 1, REACT = 2, SHOW = 3, FOUL = 4 (3 bits).
  - LFSR tap constant.
  - BCD all-9s constant function.
- Sub-module bcd_counter:
  - Parameter DIGITS.
  - Synchronous clear, increment enable, saturate flag.
  - Instantiated once for result.

Test Plan (CLK_HZ = 50000, RAND_BITS = 0, MIN_DELAY_MS = 2, DIGITS = 4):
- Basic run: start rise → go_led rises exactly 100 cycles after WAIT entry. User rise 1234 ms of ticks later → result_valid = 1, result 1234, new_best pulse, best = 1234.
- False start: user rise 50 cycles into WAIT → false_start = 1, go_led never asserts, result 0. Then start rise → WAIT again.
- Best tracking: runs of 300 ms then 450 ms → best stays 300, no new_best on the second run. A following 120 ms run → best 120 with new_best.
- Saturation: hold REACT > 9999 ms → result 9999, overflow = 1, no new_best.
- Scan/select: in SHOW with result 1234 → digit sequence 4,3,2,1 on digit_sel 0..3 and wrap. show_best = 1 switches the source to best. Repeat with DIGITS = 3 to check wrap 2 → 0.
- Async reset mid-REACT: drop rst between clock edges → all outputs 0 immediately, best = 9999, state IDLE. A held start_trigger after release does not restart.
